// File: rtl/datapath_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : riscv_pkg / datapath_sequencer_if                          |
// | Description : ALU operation encoding shared with DataPath, and the       |
// |               fetch-side / DataPath-side signal bundle of the sequencer. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;
endpackage

interface datapath_sequencer_if #(
  parameter int CNT_W = 16
);
  // instruction handshake from fetch
  logic                 instr_valid;
  logic                 instr_ready;
  logic [31:0]          instr;
  // DataPath control
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [4:0]           rd;
  riscv_pkg::alu_op_t   alu_ctrl;
  logic                 reg_write;
  logic [1:0]           mem_to_reg;
  // status
  logic                 busy;
  logic                 illegal;
  logic [CNT_W-1:0]     retired_count;
  logic [CNT_W-1:0]     illegal_count;

  // fetch side / observer
  modport master (
    output instr_valid, instr,
    input  instr_ready, rs1, rs2, rd, alu_ctrl, reg_write, mem_to_reg,
           busy, illegal, retired_count, illegal_count
  );

  // sequencer side
  modport slave (
    input  instr_valid, instr,
    output instr_ready, rs1, rs2, rd, alu_ctrl, reg_write, mem_to_reg,
           busy, illegal, retired_count, illegal_count
  );
endinterface

`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : datapath_sequencer                                         |
// | Description : Multi-cycle DECODE/EXECUTE/WRITEBACK controller driving    |
// |               the register-file/ALU DataPath for RV32 R-type words.      |
// |               Flags illegal encodings, counts retired instructions.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module datapath_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  datapath_sequencer_if.slave   bus
);

  localparam logic [6:0] c_opc_op  = 7'b0110011;
  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  // RV32 instruction words are XLEN wide in this core
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  alu_op_t           alu_ctrl_q, alu_ctrl_d;
  logic              reg_write_q, reg_write_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_count_q, retired_count_d;
  logic [CNT_W-1:0]  illegal_count_q, illegal_count_d;

  logic              dec_legal;
  alu_op_t           dec_op;

  // Recognise the supported R-type encodings and pick the ALU operation.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    if (instr_q[6:0] == c_opc_op) begin
      case (instr_q[31:25])
        c_f7_base: begin
          dec_legal = 1'b1;
          case (instr_q[14:12])
            3'b000:  dec_op = ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end
        c_f7_alt: begin
          case (instr_q[14:12])
            3'b000: begin
              dec_legal = 1'b1;
              dec_op    = ALU_SUB;
            end
            3'b101: begin
              dec_legal = 1'b1;
              dec_op    = ALU_SRA;
            end
            default: dec_legal = 1'b0;
          endcase
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Next-state and next-output logic; DataPath controls hold unless reloaded.
  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    rs1_d           = rs1_q;
    rs2_d           = rs2_q;
    rd_d            = rd_q;
    alu_ctrl_d      = alu_ctrl_q;
    reg_write_d     = 1'b0;
    illegal_d       = 1'b0;
    retired_count_d = retired_count_q;
    illegal_count_d = illegal_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          rs1_d      = instr_q[19:15];
          rs2_d      = instr_q[24:20];
          rd_d       = instr_q[11:7];
          alu_ctrl_d = dec_op;
          state_d    = S_EXECUTE;
        end else begin
          illegal_d       = 1'b1;
          illegal_count_d = illegal_count_q + CNT_W'(1);
          state_d         = S_IDLE;
        end
      end
      S_EXECUTE: begin
        // the write strobe is set up here so it is high for all of WRITEBACK;
        // x0 is never written
        reg_write_d = (rd_q != 5'd0);
        state_d     = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        retired_count_d = retired_count_q + CNT_W'(1);
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      instr_q         <= '0;
      rs1_q           <= 5'd0;
      rs2_q           <= 5'd0;
      rd_q            <= 5'd0;
      alu_ctrl_q      <= ALU_ADD;
      reg_write_q     <= 1'b0;
      illegal_q       <= 1'b0;
      retired_count_q <= '0;
      illegal_count_q <= '0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      rs1_q           <= rs1_d;
      rs2_q           <= rs2_d;
      rd_q            <= rd_d;
      alu_ctrl_q      <= alu_ctrl_d;
      reg_write_q     <= reg_write_d;
      illegal_q       <= illegal_d;
      retired_count_q <= retired_count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign bus.instr_ready   = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.rs1           = rs1_q;
  assign bus.rs2           = rs2_q;
  assign bus.rd            = rd_q;
  assign bus.alu_ctrl      = alu_ctrl_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.mem_to_reg    = 2'b00;   // only ALU results are written back
  assign bus.illegal       = illegal_q;
  assign bus.retired_count = retired_count_q;
  assign bus.illegal_count = illegal_count_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_datapath_sequencer                                      |
// | Description : Self-checking bench; a small register file/ALU stands in   |
// |               for DataPath, a reference model predicts every result.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_datapath_sequencer;
  import riscv_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datapath_sequencer_if #(.CNT_W(CNT_W)) bus ();

  datapath_sequencer #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0]      ref_x [32];
  logic [CNT_W-1:0] ref_ret;
  logic [CNT_W-1:0] ref_ill;

  // stand-in DataPath: commits at the clock edge while reg_write is high
  logic [31:0] xreg [32];
  logic        seed_en = 1'b0;

  function automatic logic [31:0] dp_alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (seed_en) begin
      for (int i = 0; i < 32; i++) xreg[i] <= ref_x[i];
    end else if (bus.reg_write && bus.rd != 5'd0) begin
      xreg[bus.rd] <= dp_alu(bus.alu_ctrl, xreg[bus.rs1], xreg[bus.rs2]);
    end
  end

  // instruction kind: 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and; -1 illegal
  function automatic int ref_kind(logic [31:0] w);
    int k;
    k = -1;
    if (w[6:0] == 7'b0110011) begin
      if (w[31:25] == 7'b0000000) begin
        case (w[14:12])
          3'd0: k = 0;
          3'd1: k = 2;
          3'd2: k = 3;
          3'd3: k = 4;
          3'd4: k = 5;
          3'd5: k = 6;
          3'd6: k = 8;
          default: k = 9;
        endcase
      end else if (w[31:25] == 7'b0100000) begin
        if (w[14:12] == 3'd0) k = 1;
        else if (w[14:12] == 3'd5) k = 7;
      end
    end
    return k;
  endfunction

  function automatic alu_op_t ref_op(int k);
    case (k)
      1: return ALU_SUB;   2: return ALU_SLL;  3: return ALU_SLT;
      4: return ALU_SLTU;  5: return ALU_XOR;  6: return ALU_SRL;
      7: return ALU_SRA;   8: return ALU_OR;   9: return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(int k, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (k)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return $signed(a) >>> sh;
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  // copy the reference register contents into the stand-in DataPath
  task automatic seed_regs();
    @(negedge clk);
    seed_en = 1'b1;
    @(posedge clk);
    #1 seed_en = 1'b0;
    @(negedge clk);
  endtask

  // issue one word with a single-cycle valid pulse and check every cycle after E0
  task automatic exec_check(input logic [31:0] w, input string tag);
    int               k;
    int               n;
    logic [4:0]       e_rs1, e_rs2, e_rd;
    logic [31:0]      res;
    logic [CNT_W-1:0] e_cnt;
    logic [22:0]      got, exp;
    k     = ref_kind(w);
    e_rs1 = w[19:15];
    e_rs2 = w[24:20];
    e_rd  = w[11:7];
    res   = ref_result(k, ref_x[e_rs1], ref_x[e_rs2]);
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_issue got=%b want=1", tag, bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(negedge clk);                           // cycle 1
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
    checks++;
    if ({bus.instr_ready, bus.busy, bus.reg_write, bus.illegal} !== 4'b0100) begin
      failures++;
      $display("FAIL %s cyc1 flags got=%b want=0100", tag,
               {bus.instr_ready, bus.busy, bus.reg_write, bus.illegal});
    end
    @(negedge clk);                           // cycle 2
    if (k >= 0) begin
      got = {bus.instr_ready, bus.busy, bus.reg_write, bus.illegal,
             bus.rs1, bus.rs2, bus.rd, 4'(bus.alu_ctrl)};
      exp = {4'b0100, e_rs1, e_rs2, e_rd, 4'(ref_op(k))};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s cyc2_execute got=%h want=%h", tag, got, exp);
      end
      @(negedge clk);                         // cycle 3
      got = {bus.instr_ready, bus.busy, bus.reg_write, bus.illegal,
             bus.rs1, bus.rs2, bus.rd, 4'(bus.alu_ctrl)};
      exp = {2'b01, e_rd != 5'd0, 1'b0, e_rs1, e_rs2, e_rd, 4'(ref_op(k))};
      checks++;
      if (got !== exp || bus.mem_to_reg !== 2'b00) begin
        failures++;
        $display("FAIL %s cyc3_writeback got=%h want=%h mem_to_reg=%b", tag, got, exp,
                 bus.mem_to_reg);
      end
      @(negedge clk);                         // cycle 4
      if (e_rd != 5'd0) ref_x[e_rd] = res;
      e_cnt   = ref_ret + 1'b1;
      ref_ret = e_cnt;
      checks++;
      if ({bus.instr_ready, bus.busy, bus.reg_write, bus.illegal} !== 4'b1000 ||
          bus.retired_count !== e_cnt) begin
        failures++;
        $display("FAIL %s cyc4_done flags=%b want=1000 retired=%h want=%h", tag,
                 {bus.instr_ready, bus.busy, bus.reg_write, bus.illegal},
                 bus.retired_count, e_cnt);
      end
      checks++;
      if (xreg[e_rd] !== ref_x[e_rd]) begin
        failures++;
        $display("FAIL %s regfile x%0d got=%h want=%h", tag, e_rd, xreg[e_rd], ref_x[e_rd]);
      end
    end else begin
      e_cnt   = ref_ill + 1'b1;
      ref_ill = e_cnt;
      checks++;
      if ({bus.instr_ready, bus.busy, bus.reg_write, bus.illegal} !== 4'b1001 ||
          bus.illegal_count !== e_cnt || bus.retired_count !== ref_ret) begin
        failures++;
        $display("FAIL %s cyc2_illegal flags=%b want=1001 ill_cnt=%h want=%h ret=%h want=%h",
                 tag, {bus.instr_ready, bus.busy, bus.reg_write, bus.illegal},
                 bus.illegal_count, e_cnt, bus.retired_count, ref_ret);
      end
      @(negedge clk);                         // cycle 3
      checks++;
      if ({bus.instr_ready, bus.busy, bus.reg_write, bus.illegal} !== 4'b1000) begin
        failures++;
        $display("FAIL %s cyc3_pulse_end flags=%b want=1000", tag,
                 {bus.instr_ready, bus.busy, bus.reg_write, bus.illegal});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.instr_ready, bus.busy, bus.reg_write, bus.illegal, bus.mem_to_reg,
         bus.rs1, bus.rs2, bus.rd, 4'(bus.alu_ctrl), bus.retired_count, bus.illegal_count}
        !== {4'b1000, 2'b00, 15'd0, 4'(ALU_ADD), 32'd0}) begin
      failures++;
      $display("FAIL reset_state ready=%b busy=%b rw=%b ill=%b rs1=%0d rs2=%0d rd=%0d alu=%0d ret=%h illc=%h",
               bus.instr_ready, bus.busy, bus.reg_write, bus.illegal, bus.rs1, bus.rs2,
               bus.rd, bus.alu_ctrl, bus.retired_count, bus.illegal_count);
    end
    rst = 1'b0;
    ref_ret = '0;
    ref_ill = '0;
    @(negedge clk);
  endtask

  task automatic test_add();
    for (int i = 0; i < 32; i++) ref_x[i] = 32'd0;
    ref_x[1] = 32'd10;
    ref_x[2] = 32'd20;
    seed_regs();
    exec_check(32'h002081B3, "add_x3");
    checks++;
    if (xreg[3] !== 32'd30 || bus.retired_count !== 16'd1) begin
      failures++;
      $display("FAIL add_x3_result x3=%0d want=30 retired=%0d want=1", xreg[3], bus.retired_count);
    end
  endtask

  task automatic test_back_to_back();
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h40110233;           // sub x4,x2,x1
    @(negedge clk);
    bus.instr       = 32'h0020C2B3;           // xor x5,x1,x2, valid held high
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.instr_ready !== 1'b0 || bus.busy !== 1'b1 ||
          (c == 3 && (bus.reg_write !== 1'b1 || bus.rd !== 5'd4))) begin
        failures++;
        $display("FAIL b2b_busy_cyc%0d ready=%b busy=%b rw=%b rd=%0d", c,
                 bus.instr_ready, bus.busy, bus.reg_write, bus.rd);
      end
      @(negedge clk);
    end
    ref_x[4] = 32'd10;
    ref_ret  = ref_ret + 1'b1;
    checks++;
    if (bus.instr_ready !== 1'b1 || xreg[4] !== 32'd10 || bus.retired_count !== ref_ret) begin
      failures++;
      $display("FAIL b2b_first_done ready=%b x4=%0d want=10 retired=%0d want=%0d",
               bus.instr_ready, xreg[4], bus.retired_count, ref_ret);
    end
    @(negedge clk);                           // cycle 5: second word accepted at E4
    bus.instr_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.rd !== 5'd4) begin
      failures++;
      $display("FAIL b2b_second_accept busy=%b want=1 rd=%0d want=4", bus.busy, bus.rd);
    end
    repeat (2) @(negedge clk);                // cycle 7: writeback of xor
    checks++;
    if (bus.reg_write !== 1'b1 || bus.rd !== 5'd5 || bus.alu_ctrl !== ALU_XOR) begin
      failures++;
      $display("FAIL b2b_second_wb rw=%b rd=%0d alu=%0d", bus.reg_write, bus.rd, bus.alu_ctrl);
    end
    @(negedge clk);
    ref_x[5] = 32'd30;
    ref_ret  = ref_ret + 1'b1;
    checks++;
    if (bus.instr_ready !== 1'b1 || xreg[5] !== 32'd30 || bus.retired_count !== ref_ret) begin
      failures++;
      $display("FAIL b2b_second_done ready=%b x5=%0d want=30 retired=%0d want=%0d",
               bus.instr_ready, xreg[5], bus.retired_count, ref_ret);
    end
  endtask

  task automatic test_rd_zero();
    exec_check(32'h00208033, "add_x0");
  endtask

  task automatic test_illegal();
    logic [CNT_W-1:0] ret0;
    ret0 = ref_ret;
    exec_check(32'h0020A1B7, "illegal_opcode");
    exec_check(32'h022081B3, "illegal_funct7");
    checks++;
    if (bus.illegal_count !== 16'd2 || bus.retired_count !== ret0) begin
      failures++;
      $display("FAIL illegal_totals ill_cnt=%0d want=2 retired=%0d want=%0d",
               bus.illegal_count, bus.retired_count, ret0);
    end
  endtask

  task automatic test_reset_mid();
    ref_x[3] = 32'd99;
    seed_regs();
    // reset while in EXECUTE
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h002081B3;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.instr_ready, bus.busy, bus.reg_write, bus.retired_count, bus.illegal_count}
        !== {3'b100, 32'd0}) begin
      failures++;
      $display("FAIL rst_in_execute ready=%b busy=%b rw=%b ret=%0d illc=%0d", bus.instr_ready,
               bus.busy, bus.reg_write, bus.retired_count, bus.illegal_count);
    end
    @(negedge clk);
    rst = 1'b0;
    ref_ret = '0;
    ref_ill = '0;
    // reset while in WRITEBACK: the write strobe must drop without a clock edge
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.reg_write !== 1'b1) begin
      failures++;
      $display("FAIL rst_wb_setup rw=%b want=1", bus.reg_write);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.reg_write !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_writeback rw=%b want=0 busy=%b want=0", bus.reg_write, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (xreg[3] !== 32'd99 || bus.retired_count !== 16'd0 || bus.instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_abandon x3=%0d want=99 retired=%0d want=0 ready=%b",
               xreg[3], bus.retired_count, bus.instr_ready);
    end
    exec_check(32'h002081B3, "add_after_reset");
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.retired_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.retired_count_q;
    ref_ret = 16'hFFFF;
    exec_check(32'h0020E333, "or_wrap");       // or x6,x1,x2
    checks++;
    if (bus.retired_count !== 16'd0) begin
      failures++;
      $display("FAIL retired_wrap got=%h want=0000", bus.retired_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int          r;
    for (int i = 1; i < 32; i++) ref_x[i] = $urandom;
    seed_regs();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      w[31:25] = (r < 5) ? 7'b0000000 : (r < 8) ? 7'b0100000 : 7'($urandom);
      w[24:7]  = 18'($urandom);
      w[6:0]   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'b0110011;
      exec_check(w, $sformatf("rand%0d_%h", n, w));
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    ref_ret         = '0;
    ref_ill         = '0;
    for (int i = 0; i < 32; i++) ref_x[i] = 32'd0;
    test_reset();
    test_add();
    test_back_to_back();
    test_rd_zero();
    test_illegal();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
